// File: rtl/vga_scan_generator_pkg.sv
// vga_timing_pkg: 640x480@60 raster timing constants, colour type and range helper
package vga_timing_pkg;
    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_VIS_START = 143;
    localparam int H_VIS_END   = 782;
    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_VIS_START = 31;
    localparam int V_VIS_END   = 510;
    typedef logic [11:0] rgb12_t;
    function automatic logic in_span(input logic [9:0] a, input logic [9:0] lo, input logic [9:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction
endpackage

// File: rtl/vga_scan_generator_if.sv
// vga_scan_generator_if: pixel-source and VGA-connector signals of the scan generator
interface vga_scan_generator_if;
    import vga_timing_pkg::*;
    rgb12_t     rgb_in;
    logic [9:0] x;
    logic [9:0] y;
    logic       pix_tick;
    logic       visible;
    logic       frame_start;
    logic       hsync;
    logic       vsync;
    rgb12_t     rgb_out;
    modport master (input rgb_in, output x, y, pix_tick, visible, frame_start, hsync, vsync, rgb_out);
    modport slave (output rgb_in, input x, y, pix_tick, visible, frame_start, hsync, vsync, rgb_out);
endinterface

// File: rtl/vga_scan_generator_pixel_tick_gen.sv
// pixel_tick_gen: divides the system clock down to a one-clk pulse per pixel period
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV) + 1;
    logic [W-1:0] div;
    assign tick = div == W'(CLK_DIV - 1);
    // count 0..CLK_DIV-1, wrapping on the tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div <= '0;
        else div <= tick ? '0 : div + W'(1);
    end
endmodule

// File: rtl/vga_scan_generator.sv
// vga_scan_generator: raster counters, visible/sync decode and pixel-aligned output stage
module vga_scan_generator #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_VIS_START = vga_timing_pkg::H_VIS_START,
    parameter int H_VIS_END   = vga_timing_pkg::H_VIS_END,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_VIS_START = vga_timing_pkg::V_VIS_START,
    parameter int V_VIS_END   = vga_timing_pkg::V_VIS_END
) (
    input logic                  clk,
    input logic                  rst,
    vga_scan_generator_if.master bus
);
    import vga_timing_pkg::*;
    logic [9:0] h;
    logic [9:0] v;
    logic       tick;
    logic       h_end;
    logic       v_end;
    logic       vis;
    logic       hs_q;
    logic       vs_q;
    rgb12_t     rgb_q;
    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
    assign h_end = h == 10'(H_TOTAL - 1);
    assign v_end = v == 10'(V_TOTAL - 1);
    assign vis   = in_span(h, 10'(H_VIS_START), 10'(H_VIS_END)) && in_span(v, 10'(V_VIS_START), 10'(V_VIS_END));
    // advance the raster one pixel per tick; v steps only when a line wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            h <= h_end ? '0 : h + 10'd1;
            v <= h_end ? (v_end ? '0 : v + 10'd1) : v;
        end
    end
    // delay sync and gated colour by one pixel so they stay aligned with each other
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= '0;
        end else if (tick) begin
            hs_q  <= !(h < 10'(H_SYNC));
            vs_q  <= !(v < 10'(V_SYNC));
            rgb_q <= vis ? bus.rgb_in : 12'h000;
        end
    end
    assign bus.x           = h;
    assign bus.y           = v;
    assign bus.pix_tick    = tick;
    assign bus.visible     = vis;
    assign bus.frame_start = tick && h_end && v_end;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.rgb_out     = rgb_q;
endmodule

// File: tb/tb_vga_scan_generator.sv
// tb_vga_scan_generator: scoreboard bench against a pixel-index raster model
module tb_vga_scan_generator;
    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        vis;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;
    typedef struct packed {
        int ht; int hsy; int hvs; int hve;
        int vt; int vsy; int vvs; int vve;
    } tim_t;
    localparam tim_t TA = '{800, 96, 143, 782, 525, 2, 31, 510};
    localparam tim_t TB = '{12, 3, 4, 9, 8, 2, 2, 5};
    logic clk = 0;
    logic rst_a = 1;
    logic rst_b = 1;
    int   checks = 0;
    int   errors = 0;
    int   fsa = 0;
    int   fsb = 0;
    int   gb = 0;
    exp_t qa[$];
    exp_t qb[$];
    vga_scan_generator_if ia();
    vga_scan_generator_if ib();
    vga_scan_generator #(.CLK_DIV(1)) u_a (.clk(clk), .rst(rst_a), .bus(ia.master));
    vga_scan_generator #(
        .CLK_DIV(4), .H_TOTAL(12), .H_SYNC(3), .H_VIS_START(4), .H_VIS_END(9),
        .V_TOTAL(8), .V_SYNC(2), .V_VIS_START(2), .V_VIS_END(5)
    ) u_b (.clk(clk), .rst(rst_b), .bus(ib.master));
    // free-running system clock
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic exp_t pack_a();
        return {ia.x, ia.y, ia.visible, ia.frame_start, ia.hsync, ia.vsync, ia.rgb_out};
    endfunction
    function automatic exp_t pack_b();
        return {ib.x, ib.y, ib.visible, ib.frame_start, ib.hsync, ib.vsync, ib.rgb_out};
    endfunction
    function automatic logic in_vis(input int h, input int v, input tim_t t);
        return h >= t.hvs && h <= t.hve && v >= t.vvs && v <= t.vve;
    endfunction
    function automatic exp_t exp_of(input int n, input tim_t t, input logic [11:0] rp);
        exp_t e;
        int h, v, hp, vp;
        h = n % t.ht;
        v = (n / t.ht) % t.vt;
        e.x = 10'(h);
        e.y = 10'(v);
        e.vis = in_vis(h, v, t);
        e.fs = h == t.ht - 1 && v == t.vt - 1;
        if (n == 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            e.rgb = 12'h000;
        end else begin
            hp = (n - 1) % t.ht;
            vp = ((n - 1) / t.ht) % t.vt;
            e.hs = hp >= t.hsy;
            e.vs = vp >= t.vsy;
            e.rgb = in_vis(hp, vp, t) ? rp : 12'h000;
        end
        return e;
    endfunction
    task automatic set_rst(input bit sel, input logic r);
        if (sel) rst_b = r;
        else rst_a = r;
    endtask
    task automatic do_reset(input bit sel);
        exp_t rv;
        rv = '{x: 10'd0, y: 10'd0, vis: 1'b0, fs: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 12'h000};
        set_rst(sel, 1'b1);
        if (sel) qb.delete();
        else qa.delete();
        #1;
        check(sel ? "b_reset_outs" : "a_reset_outs", sel ? pack_b() : pack_a(), rv);
        check(sel ? "b_reset_tick" : "a_reset_tick", sel ? ib.pix_tick : ia.pix_tick, sel ? 64'd0 : 64'd1);
        repeat (3) @(posedge clk);
        #1;
        set_rst(sel, 1'b0);
    endtask
    task automatic wait_tick(input bit sel);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(sel ? ib.pix_tick : ia.pix_tick) && c < 64);
        if (!(sel ? ib.pix_tick : ia.pix_tick)) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: no pix_tick within %0d clks on dut %0d", c, sel);
        end
        @(posedge clk);
        #1;
    endtask
    task automatic run(input bit sel, input tim_t t, input int npix, input int rst_at);
        int n, fexp;
        logic [11:0] r, rp;
        exp_t e;
        n = 0;
        fexp = 0;
        rp = '0;
        for (int k = 0; k < npix; k++) begin
            if (k == 0 || k == rst_at) begin
                do_reset(sel);
                n = 0;
                fexp = 0;
            end
            r = $urandom_range(0, 1) ? {2'b00, 10'(n % t.ht)} : 12'($urandom);
            if (sel) ib.rgb_in = r;
            else ia.rgb_in = r;
            e = exp_of(n, t, rp);
            if (e.fs) fexp++;
            if (sel) qb.push_back(e);
            else qa.push_back(e);
            wait_tick(sel);
            rp = r;
            n++;
        end
        check(sel ? "b_frame_count" : "a_frame_count", sel ? fsb : fsa, fexp);
        check(sel ? "b_queue_empty" : "a_queue_empty", sel ? qb.size() : qa.size(), 0);
    endtask
    // monitor for the CLK_DIV=1 build at full 640x480 timing
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_a) fsa = 0;
        else begin
            check("a_tick_const", ia.pix_tick, 1);
            if (ia.frame_start) fsa++;
            if (ia.pix_tick) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected: pixel at x=%0d y=%0d with nothing expected", ia.x, ia.y);
                end else begin
                    e = qa.pop_front();
                    check("a_pix", pack_a(), e);
                end
            end
        end
    end
    // monitor for the CLK_DIV=4 build with a shrunken raster
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_b) begin
            fsb = 0;
            gb = 0;
        end else begin
            gb++;
            if (ib.frame_start) fsb++;
            if (ib.pix_tick) begin
                check("b_tick_gap", gb, 4);
                gb = 0;
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: pixel at x=%0d y=%0d with nothing expected", ib.x, ib.y);
                end else begin
                    e = qb.pop_front();
                    check("b_pix", pack_b(), e);
                end
            end
        end
    end
    // stimulus: full-timing partial frame with a mid-line reset at (400,40), then shrunken frames
    initial begin
        ia.rgb_in = '0;
        ib.rgb_in = '0;
        repeat (2) @(posedge clk);
        #1;
        run(1'b0, TA, 33400, 40 * 800 + 400);
        rst_a = 1'b1;
        run(1'b1, TB, 300, 150);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
